// File: rtl/soc_system_sysid_ext.sv
// System ID block: constant ID/timestamp/capability words, a scratch register,
// user constants and an optional 64-bit uptime counter (SOC_SYSTEM_SYSID_UPTIME_EN).
module soc_system_sysid_ext #(
  parameter logic [31:0]  ID_VALUE       = 32'h5925_2795,
  parameter logic [31:0]  TIMESTAMP      = 32'hACD5_C882,
  parameter int           NUM_USER_WORDS = 2,
  parameter logic [255:0] USER_WORDS     = 256'h0,
  parameter int           READ_LATENCY   = 1,
  parameter logic [31:0]  SCRATCH_INIT   = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

`ifdef SOC_SYSTEM_SYSID_UPTIME_EN
  localparam logic UPTIME_BIT = 1'b1;
`else
  localparam logic UPTIME_BIT = 1'b0;
`endif

  localparam logic [4:0]  NUW5 = 5'(NUM_USER_WORDS);
  localparam logic [31:0] CAP  = {8'h02, 7'd0, UPTIME_BIT, 4'd0,
                                  4'(READ_LATENCY), 8'(NUM_USER_WORDS)};

  logic [31:0] r_scratch;
  logic [31:0] w_up_lo;
  logic [31:0] w_up_hi;
  logic [31:0] w_user [8];
  logic [4:0]  w_uoff;
  logic [31:0] w_rd_data;

  for (genvar k = 0; k < 8; k++) begin : g_user
    assign w_user[k] = USER_WORDS[k*32 +: 32];
  end

  assign w_uoff = {1'b0, address} - 5'd6;

  // Read data is taken from current state, so a read in the same cycle as a
  // write sees the pre-write value.
  always_comb begin
    w_rd_data = 32'h0;
    case (address)
      4'd0:    w_rd_data = ID_VALUE;
      4'd1:    w_rd_data = TIMESTAMP;
      4'd2:    w_rd_data = CAP;
      4'd3:    w_rd_data = r_scratch;
      4'd4:    w_rd_data = w_up_lo;
      4'd5:    w_rd_data = w_up_hi;
      default: if (w_uoff < NUW5) w_rd_data = w_user[w_uoff[2:0]];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_scratch <= SCRATCH_INIT;
    end else if (write && address == 4'd3) begin
      r_scratch <= writedata;
    end
  end

`ifdef SOC_SYSTEM_SYSID_UPTIME_EN
  logic [63:0] r_uptime;
  logic [31:0] r_shadow;

  // Reading the low half snapshots the high half so a lo/hi pair is coherent.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_uptime <= 64'h0;
      r_shadow <= 32'h0;
    end else begin
      if (write && address == 4'd4) r_uptime <= 64'h0;
      else                          r_uptime <= r_uptime + 64'd1;
      if (read && address == 4'd4)  r_shadow <= r_uptime[63:32];
    end
  end

  assign w_up_lo = r_uptime[31:0];
  assign w_up_hi = r_shadow;
`else
  assign w_up_lo = 32'h0;
  assign w_up_hi = 32'h0;
`endif

  // Read pipeline: valid bits shift every cycle; a data stage only loads when
  // a valid result enters it, so the last stage holds the last returned word.
  logic [READ_LATENCY-1:0]       r_vld;
  logic [READ_LATENCY-1:0][31:0] r_dat;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      r_vld[0] <= read;
      if (read) r_dat[0] <= w_rd_data;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign readdata      = r_dat[READ_LATENCY-1];
  assign readdatavalid = r_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// Bench for soc_system_sysid_ext: three parameterisations share the inputs;
// one is selected at a time and scored against an expected queue.
module tb_soc_system_sysid_ext;

`ifdef SOC_SYSTEM_SYSID_UPTIME_EN
  localparam bit UP_ON = 1'b1;
`else
  localparam bit UP_ON = 1'b0;
`endif

  localparam logic [31:0] ID_DEF  = 32'h5925_2795;
  localparam logic [31:0] TS_DEF  = 32'hACD5_C882;
  localparam logic [31:0] ID3     = 32'h1357_9BDF;
  localparam logic [31:0] SCR3    = 32'h1234_ABCD;
  localparam logic [31:0] SCR4    = 32'hA5A5_0F0F;
  localparam logic [31:0] UPB     = UP_ON ? 32'h0001_0000 : 32'h0;
  localparam logic [31:0] CAP0    = 32'h0200_0102 | UPB;
  localparam logic [31:0] CAP3    = 32'h0200_0302 | UPB;
  localparam logic [31:0] CAP4    = 32'h0200_0400 | UPB;
  localparam logic [255:0] UW3    = {160'h0, 32'hBAD0_0002, 32'hCAFE_0001, 32'h1111_2222};

  // clock / reset / stimulus signals
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = 4'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'h0;

  logic [31:0] rd0, rd3, rd4;
  logic        rdv0, rdv3, rdv4;

  always #5 clock = ~clock;

  soc_system_sysid_ext u_dut0 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rd0), .readdatavalid(rdv0));

  soc_system_sysid_ext #(
    .ID_VALUE(ID3), .NUM_USER_WORDS(2), .USER_WORDS(UW3), .READ_LATENCY(3),
    .SCRATCH_INIT(SCR3)
  ) u_dut3 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rd3), .readdatavalid(rdv3));

  soc_system_sysid_ext #(
    .NUM_USER_WORDS(0), .READ_LATENCY(4), .SCRATCH_INIT(SCR4)
  ) u_dut4 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rd4), .readdatavalid(rdv4));

  int          sel = 0;
  int          lat = 1;
  logic [31:0] m_rd;
  logic        m_rdv;

  assign m_rd  = (sel == 0) ? rd0  : (sel == 3) ? rd3  : rd4;
  assign m_rdv = (sel == 0) ? rdv0 : (sel == 3) ? rdv3 : rdv4;

  // scoreboard
  logic [31:0] exp_q[$];
  int          due_q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clock) begin
    logic [31:0] e;
    int          d;
    #1;
    cyc++;
    if (reset) begin
      check("reset_rdv", 64'(m_rdv), 64'd0);
      check("reset_rdata", 64'(m_rd), 64'd0);
      exp_q.delete();
      due_q.delete();
      last_rd = 32'h0;
    end else if (m_rdv) begin
      if (exp_q.size() == 0) begin
        check("spurious_rdv", 64'(m_rdv), 64'd0);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("rdata", 64'(m_rd), 64'(e));
        check("latency", 64'(cyc), 64'(d));
        last_rd = e;
      end
    end else begin
      check("rdata_hold", 64'(m_rd), 64'(last_rd));
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        check("rdv_missing", 64'(m_rdv), 64'd1);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // driver tasks
  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rd, logic wr, logic [3:0] a, logic [31:0] wd,
                              logic [31:0] e);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic logic [31:0] up(logic [31:0] v);
    return UP_ON ? v : 32'h0;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [3:0] a,
                       input logic [31:0] wd, input logic [31:0] e);
    @(negedge clock);
    read = rd; write = wr; address = a; writedata = wd;
    if (rd && !reset) begin
      exp_q.push_back(e);
      due_q.push_back(cyc + lat);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      read = 1'b0; write = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1; read = 1'b0; write = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_tbl;
    foreach (tbl[i]) drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
    tbl.delete();
    idle(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // defaults, latency 1
    sel = 0; lat = 1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    add(1, 0, 4'd0, 0, ID_DEF);
    add(1, 0, 4'd1, 0, TS_DEF);
    add(1, 0, 4'd2, 0, CAP0);
    add(1, 0, 4'd3, 0, 32'h0);
    add(1, 0, 4'd6, 0, 32'h0);
    add(1, 0, 4'd7, 0, 32'h0);
    add(1, 0, 4'd8, 0, 32'h0);
    add(1, 0, 4'd15, 0, 32'h0);
    add(0, 1, 4'd4, 32'h5555_5555, 0);
    for (int i = 0; i < 9; i++) add(0, 0, 4'd0, 0, 0);
    add(1, 0, 4'd4, 0, up(32'd9));
    add(1, 0, 4'd5, 0, 32'h0);
    add(1, 1, 4'd4, 0, up(32'd11));
    add(1, 0, 4'd4, 0, 32'h0);
    run_tbl();

`ifdef SOC_SYSTEM_SYSID_UPTIME_EN
    // low/high coherence across the 32-bit boundary
    @(negedge clock);
    force u_dut0.r_uptime = 64'h0000_0000_FFFF_FFFF;
    read = 1'b1; address = 4'd4;
    exp_q.push_back(32'hFFFF_FFFF); due_q.push_back(cyc + lat);
    @(negedge clock);
    address = 4'd5;
    exp_q.push_back(32'h0); due_q.push_back(cyc + lat);
    @(negedge clock);
    force u_dut0.r_uptime = 64'h0000_0003_0000_0007;
    address = 4'd4;
    exp_q.push_back(32'h7); due_q.push_back(cyc + lat);
    @(negedge clock);
    force u_dut0.r_uptime = 64'h0000_0009_0000_0000;
    address = 4'd5;
    exp_q.push_back(32'h3); due_q.push_back(cyc + lat);
    @(negedge clock);
    release u_dut0.r_uptime;
    read = 1'b0; write = 1'b1; address = 4'd4;
    @(negedge clock);
    write = 1'b0; read = 1'b1; address = 4'd4;
    exp_q.push_back(32'h0); due_q.push_back(cyc + lat);
    idle(6);
`endif

    // latency 3, user words, scratch read-during-write
    sel = 3; lat = 3;
    do_reset(2);
    add(1, 0, 4'd2, 0, CAP3);
    add(1, 0, 4'd6, 0, 32'h1111_2222);
    add(1, 0, 4'd7, 0, 32'hCAFE_0001);
    add(1, 0, 4'd15, 0, 32'h0);
    add(1, 0, 4'd8, 0, 32'h0);
    add(1, 1, 4'd3, 32'hDEAD_BEEF, SCR3);
    add(1, 0, 4'd3, 0, 32'hDEAD_BEEF);
    add(0, 1, 4'd0, 32'h1234_5678, 0);
    add(1, 0, 4'd0, 0, ID3);
    add(0, 1, 4'd2, 32'hFFFF_FFFF, 0);
    add(0, 1, 4'd7, 32'hFFFF_FFFF, 0);
    add(1, 0, 4'd2, 0, CAP3);
    add(1, 0, 4'd7, 0, 32'hCAFE_0001);
    add(1, 0, 4'd1, 0, TS_DEF);
    add(1, 0, 4'd4, 0, 32'h0);
    run_tbl();

    // latency 4, reset with three reads in flight
    sel = 4; lat = 4;
    do_reset(2);
    drive(0, 1, 4'd3, 32'h0BAD_F00D, 0);
    drive(1, 0, 4'd0, 0, ID_DEF);
    drive(1, 0, 4'd1, 0, TS_DEF);
    drive(1, 0, 4'd3, 0, 32'h0BAD_F00D);
    @(negedge clock);
    reset = 1'b1; read = 1'b1; write = 1'b1; address = 4'd3; writedata = 32'hFFFF_0000;
    @(negedge clock);
    reset = 1'b0; read = 1'b0; write = 1'b0;
    idle(8);
    add(1, 0, 4'd3, 0, SCR4);
    add(1, 0, 4'd6, 0, 32'h0);
    add(1, 0, 4'd2, 0, CAP4);
    add(1, 0, 4'd0, 0, ID_DEF);
    run_tbl();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/soc_system_sysid_ext.md
SOC_SYSTEM_SYSID_EXT -- requirements
Module: soc_system_sysid_ext

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h5925_2795, system ID word.
REQ-002 SHALL have parameter TIMESTAMP, default 32'hACD5_C882, build timestamp word.
REQ-003 SHALL have parameter NUM_USER_WORDS, default 2, range 0..8, count of user constant words.
REQ-004 SHALL have parameter USER_WORDS, default 256'h0, packed user words, word k at bits [32k+31:32k].
REQ-005 SHALL have parameter READ_LATENCY, default 1, range 1..4, cycles from read accept to readdatavalid.
REQ-006 SHALL have parameter SCRATCH_INIT, default 32'h0, scratch register reset value.
REQ-007 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-009 SHALL have port address, input, 4, word address.
REQ-010 SHALL have port read, input, 1, read request; accepted every cycle it is high.
REQ-011 SHALL have port write, input, 1, write request; accepted every cycle it is high.
REQ-012 SHALL have port writedata, input, 32, write data.
REQ-013 SHALL have port readdata, output, 32, registered read data.
REQ-014 SHALL have port readdatavalid, output, 1, one-cycle qualifier for readdata.

Function
REQ-015 SHALL decode the map: 0 ID_VALUE; 1 TIMESTAMP; 2 CAP; 3 SCRATCH (RW); 4 UPTIME_LO; 5 UPTIME_HI; 6..6+NUM_USER_WORDS-1 user words 0..N-1; all other addresses read 32'h0.
REQ-016 SHALL form CAP as [7:0] NUM_USER_WORDS, [11:8] READ_LATENCY, [16] uptime present, [31:24] 8'h02, other bits 0.
REQ-017 SHALL sample read data in the accept cycle and present it on readdata with readdatavalid high exactly READ_LATENCY cycles later.
REQ-018 SHALL be fully pipelined: back-to-back reads on consecutive cycles produce consecutive readdatavalid pulses in order; no waitrequest.
REQ-019 SHALL hold readdata at its last value and drive readdatavalid low when no result is due.
REQ-020 SHALL update SCRATCH on the clock edge of a write to address 3; visible to a read accepted the following cycle.
REQ-021 SHALL ignore writes to all addresses except 3 and 4, with no side effect.
REQ-022 SHALL maintain a 64-bit uptime counter incrementing by 1 every cycle, wrapping from 2^64-1 to 0.
REQ-023 SHALL, on a read accepted at address 4, return counter[31:0] and copy counter[63:32] into a 32-bit shadow in the same edge.
REQ-024 SHALL return the shadow (not the live upper half) on reads of address 5.
REQ-025 SHALL clear the counter to 0 on a write to address 4 (any data); clear overrides increment in that cycle.
REQ-026 SHALL, with read and write asserted together, perform both; the read returns the pre-write value.

Reset
REQ-027 SHALL, while reset is high, force readdata=0, readdatavalid=0, flush all in-flight reads, set SCRATCH=SCRATCH_INIT, counter=0, shadow=0.
REQ-028 SHALL drop reads accepted before or during reset; first readdatavalid after release only for reads accepted after release.
REQ-029 SHALL ignore read and write in cycles where reset is high.

Configuration
REQ-030 SHALL compile the uptime counter and shadow only when macro SOC_SYSTEM_SYSID_UPTIME_EN is defined; CAP[16]=1.
REQ-031 SHALL, without SOC_SYSTEM_SYSID_UPTIME_EN, read addresses 4 and 5 as 32'h0, ignore writes to 4, set CAP[16]=0, and instantiate no counter flops.

Verification
REQ-032 SHALL cover: defaults, reset release, read addr 0 then 1 back-to-back -> readdatavalid on cycles +1,+2 with 32'h5925_2795, 32'hACD5_C882.
REQ-033 SHALL cover: READ_LATENCY=3, NUM_USER_WORDS=2, reads 2,6,7,15 -> data 0x0201_0302 (uptime on), user0, user1, 0 at +3..+6 cycles.
REQ-034 SHALL cover: write 0xDEAD_BEEF to 3 with simultaneous read of 3 -> old value SCRATCH_INIT returned; next-cycle read returns 0xDEAD_BEEF; write to 0 leaves ID unchanged.
REQ-035 SHALL cover: uptime on, clear via write to 4 at cycle T, read 4 at T+10 -> 9; read 5 -> 0; force counter to 0x0000_0000_FFFF_FFFF, read 4 then 5 -> 0xFFFF_FFFF then 0x0.
REQ-036 SHALL cover: three reads in flight (READ_LATENCY=4), reset pulsed one cycle -> no readdatavalid until a new post-reset read, SCRATCH back to SCRATCH_INIT.
REQ-037 SHALL cover: macro undefined -> reads of 4 and 5 return 0, CAP[16]=0.
